// File: rtl/axilite_cfg_pkg.sv
// rtl/axilite_cfg_pkg.sv - copy-engine register map, response codes and sequencer states
package axilite_cfg_pkg;

    localparam logic [31:0] REG_START   = 32'h0;
    localparam logic [31:0] REG_DONE    = 32'h4;
    localparam logic [31:0] REG_WR_BASE = 32'h8;
    localparam logic [31:0] REG_RD_BASE = 32'hC;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_POLL_GAP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_FINISH
    } state_t;

    // Register targeted by each of the three configuration writes, in issue order.
    function automatic logic [31:0] cfg_reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return REG_RD_BASE;
            2'd1:    return REG_WR_BASE;
            default: return REG_START;
        endcase
    endfunction

endpackage

// File: rtl/axilite_cfg_sequencer_if.sv
// rtl/axilite_cfg_sequencer_if.sv - AXI-Lite bus between the sequencer and the copy engine
interface axilite_cfg_sequencer_if;

    logic        AWVALID;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWREADY;
    logic        WVALID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WREADY;
    logic        BREADY;
    logic        BVALID;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARREADY;
    logic        RREADY;
    logic        RVALID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, input AWREADY,
        output WVALID, WDATA, WSTRB, input WREADY,
        output BREADY, input BVALID, BRESP,
        output ARVALID, ARADDR, ARPROT, input ARREADY,
        output RREADY, input RVALID, RDATA, RRESP
    );

    modport slave (
        input AWVALID, AWADDR, AWPROT, output AWREADY,
        input WVALID, WDATA, WSTRB, output WREADY,
        input BREADY, output BVALID, BRESP,
        input ARVALID, ARADDR, ARPROT, output ARREADY,
        input RREADY, output RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axilite_wr_xact.sv
// rtl/axilite_wr_xact.sv - single-beat AXI-Lite write (AW + W, then B)
module axilite_wr_xact
    import axilite_cfg_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        awvalid,
    output logic [31:0] awaddr,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    input  logic        wready,
    output logic        bready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        accepted,
    output logic        done,
    output logic        err
);

    // Both request channels are finished once each is either already gone or handshaking now.
    assign accepted = (awvalid || wvalid) &&
                      (!awvalid || awready) &&
                      (!wvalid  || wready);
    assign done     = bready && bvalid;
    assign err      = done && (bresp != RESP_OKAY);

    // AW and W retire independently; B is only accepted once both have gone.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            bready  <= 1'b0;
        end else begin
            if (start) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= addr;
                wdata   <= data;
            end else begin
                if (awvalid && awready) awvalid <= 1'b0;
                if (wvalid && wready)   wvalid  <= 1'b0;
            end
            if (accepted)
                bready <= 1'b1;
            else if (done)
                bready <= 1'b0;
        end
    end

endmodule

// File: rtl/axilite_cfg_sequencer.sv
// rtl/axilite_cfg_sequencer.sv - programs and polls the copy engine, one job at a time
module axilite_cfg_sequencer
    import axilite_cfg_pkg::*;
#(
    parameter int POLL_GAP      = 16,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_rd_base,
    input  logic [31:0] job_wr_base,
    output logic        job_done,
    output logic        job_err,
    output logic        busy,
    axilite_cfg_sequencer_if.master axilite
);

    state_t      state_q, state_d;
    logic        ready_en;
    logic [31:0] wr_base_q;
    logic [1:0]  wr_idx;
    logic [31:0] gap_cnt;
    logic [31:0] poll_cnt;
    logic [31:0] poll_next;
    logic        timeout_hit;
    logic        err_q;

    logic        wr_start;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_accepted;
    logic        wr_done;
    logic        wr_err;

    axilite_wr_xact u_wr_xact (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .start    (wr_start),
        .addr     (wr_addr),
        .data     (wr_data),
        .awvalid  (axilite.AWVALID),
        .awaddr   (axilite.AWADDR),
        .awready  (axilite.AWREADY),
        .wvalid   (axilite.WVALID),
        .wdata    (axilite.WDATA),
        .wready   (axilite.WREADY),
        .bready   (axilite.BREADY),
        .bvalid   (axilite.BVALID),
        .bresp    (axilite.BRESP),
        .accepted (wr_accepted),
        .done     (wr_done),
        .err      (wr_err)
    );

    assign axilite.AWPROT  = 3'b000;
    assign axilite.ARPROT  = 3'b000;
    assign axilite.WSTRB   = 4'hF;
    assign axilite.ARVALID = (state_q == ST_RD_REQ);
    assign axilite.ARADDR  = (state_q == ST_RD_REQ) ? REG_DONE : '0;
    assign axilite.RREADY  = (state_q == ST_RD_RESP);

    // ready_en keeps job_ready low for the first cycle after reset release
    assign job_ready = ready_en && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign job_done  = (state_q == ST_FINISH);
    assign job_err   = job_done && err_q;

    assign poll_next   = (poll_cnt == 32'hFFFF_FFFF) ? poll_cnt : poll_cnt + 32'd1;
    assign timeout_hit = (TIMEOUT_POLLS != 0) && (poll_next == 32'(TIMEOUT_POLLS));

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state, and the address/data launched into the write engine on each write start
    always_comb begin
        state_d  = state_q;
        wr_start = 1'b0;
        wr_addr  = REG_RD_BASE;
        wr_data  = job_rd_base;
        case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready) begin
                    state_d  = ST_WR_REQ;
                    wr_start = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (wr_accepted) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (wr_done) begin
                    if (wr_err) begin
                        state_d = ST_FINISH;
                    end else if (wr_idx == 2'd2) begin
                        state_d = ST_POLL_GAP;
                    end else begin
                        state_d  = ST_WR_REQ;
                        wr_start = 1'b1;
                        wr_addr  = cfg_reg_addr(wr_idx + 2'd1);
                        wr_data  = (wr_idx == 2'd0) ? wr_base_q : 32'd1;
                    end
                end
            end
            ST_POLL_GAP: begin
                if (gap_cnt >= 32'(POLL_GAP - 1)) state_d = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (axilite.ARREADY) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (axilite.RVALID) begin
                    if ((axilite.RRESP != RESP_OKAY) || axilite.RDATA[0] || timeout_hit)
                        state_d = ST_FINISH;
                    else
                        state_d = ST_POLL_GAP;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Job context: latched bases, write index, poll gap/count and the error cause
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en  <= 1'b0;
            wr_base_q <= '0;
            wr_idx    <= '0;
            gap_cnt   <= '0;
            poll_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (job_valid && job_ready) begin
                        wr_base_q <= job_wr_base;
                        wr_idx    <= '0;
                        poll_cnt  <= '0;
                        err_q     <= 1'b0;
                    end
                end
                ST_WR_RESP: begin
                    gap_cnt <= '0;
                    if (wr_done) begin
                        if (wr_err) err_q  <= 1'b1;
                        else        wr_idx <= wr_idx + 2'd1;
                    end
                end
                ST_POLL_GAP: gap_cnt <= gap_cnt + 32'd1;
                ST_RD_RESP: begin
                    gap_cnt <= '0;
                    if (axilite.RVALID) begin
                        if (axilite.RRESP != RESP_OKAY) begin
                            err_q <= 1'b1;
                        end else if (!axilite.RDATA[0]) begin
                            poll_cnt <= poll_next;
                            if (timeout_hit) err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
